// File: rtl/sw_frame_responder.sv
// Switch-side frame consumer: pops request frames from the per-switch FIFO,
// executes them against a local register bank and returns a tagged response.
module sw_frame_responder #(
    parameter int W_WIDTH     = 8,
    parameter int FRAME_WIDTH = 32,
    parameter int NUM_REGS    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [FRAME_WIDTH-1:0] fifo_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [7:0]             resp_op_id,
    output logic                   resp_wr_rd,
    output logic [W_WIDTH-1:0]     resp_data,
    output logic                   resp_err,
    output logic                   busy,
    output logic [7:0]             err_cnt
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POP  = 3'd1,
        CAP  = 3'd2,
        EXEC = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic [FRAME_WIDTH-1:0]   frame_r;
    logic [W_WIDTH-1:0]       regs_r [NUM_REGS];
    logic [7:0]               resp_op_id_r;
    logic                     resp_wr_rd_r;
    logic [W_WIDTH-1:0]       resp_data_r;
    logic                     resp_err_r;
    logic [7:0]               err_cnt_r;

    logic [4:0]               addr_s;
    logic [AW-1:0]            idx_s;
    logic                     wr_rd_s;
    logic [W_WIDTH-1:0]       wdata_s;
    logic                     err_s;
    logic [W_WIDTH-1:0]       rdata_s;

    // Reserved bits must be clear and the address must hit an implemented register.
    function automatic logic frame_illegal(input logic [FRAME_WIDTH-1:0] f);
        logic [4:0] a;
        a = f[21:17];
        return (int'(a) >= NUM_REGS) || (f[FRAME_WIDTH-1:22] != '0);
    endfunction

    // Fit the 8-bit frame data field to the register width.
    function automatic logic [W_WIDTH-1:0] fit_wdata(input logic [7:0] b);
        logic [W_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; (i < W_WIDTH) && (i < 8); i++) begin
            r[i] = b[i];
        end
        return r;
    endfunction

    assign addr_s  = frame_r[21:17];
    assign idx_s   = addr_s[AW-1:0];
    assign wr_rd_s = frame_r[16];
    assign wdata_s = fit_wdata(frame_r[15:8]);
    assign err_s   = frame_illegal(frame_r);

    // Read port of the bank; illegal frames return zero.
    always_comb begin
        rdata_s = '0;
        if (!err_s) begin
            rdata_s = regs_r[idx_s];
        end else begin
            rdata_s = '0;
        end
    end

    // Next-state logic for the pop / capture / execute / respond sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty) begin
                    state_s = POP;
                end else begin
                    state_s = IDLE;
                end
            end
            POP:  state_s = CAP;
            CAP:  state_s = EXEC;
            EXEC: state_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame capture, response registers and saturating illegal-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r      <= '0;
            resp_op_id_r <= 8'd0;
            resp_wr_rd_r <= 1'b0;
            resp_data_r  <= '0;
            resp_err_r   <= 1'b0;
            err_cnt_r    <= 8'd0;
        end else begin
            if (state_r == CAP) begin
                frame_r <= fifo_data;
            end
            if (state_r == EXEC) begin
                resp_op_id_r <= frame_r[7:0];
                resp_wr_rd_r <= wr_rd_s;
                resp_err_r   <= err_s;
                if (err_s) begin
                    resp_data_r <= '0;
                    if (err_cnt_r != 8'hFF) begin
                        err_cnt_r <= err_cnt_r + 8'd1;
                    end
                end else if (wr_rd_s) begin
                    resp_data_r <= wdata_s;
                end else begin
                    resp_data_r <= rdata_s;
                end
            end
        end
    end

    // Register bank; written only by a legal write in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            if ((state_r == EXEC) && wr_rd_s && !err_s) begin
                regs_r[idx_s] <= wdata_s;
            end
        end
    end

    assign fifo_rd_en = (state_r == POP);
    assign resp_valid = (state_r == RESP);
    assign busy       = (state_r != IDLE);
    assign resp_op_id = resp_op_id_r;
    assign resp_wr_rd = resp_wr_rd_r;
    assign resp_data  = resp_data_r;
    assign resp_err   = resp_err_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_sw_frame_responder.sv
// Directed bench for sw_frame_responder (NUM_REGS = 16) with a queue-backed FIFO model.
module tb_sw_frame_responder;

    logic        clk;
    logic        rst_n;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_op_id;
    logic        resp_wr_rd;
    logic [7:0]  resp_data;
    logic        resp_err;
    logic        busy;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int pop_cnt = 0;
    logic [31:0] fq [$];

    typedef struct packed {
        logic       to;
        logic [7:0] op;
        logic       wr;
        logic [7:0] data;
        logic       err;
    } resp_t;

    sw_frame_responder #(.W_WIDTH(8), .FRAME_WIDTH(32), .NUM_REGS(16)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_data(fifo_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_op_id(resp_op_id), .resp_wr_rd(resp_wr_rd), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: a pop presents the head entry for the following cycle.
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            pop_cnt++;
            if (fq.size() > 0) fifo_data = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
    end

    task automatic push(input logic [31:0] f);
        fq.push_back(f);
        fifo_empty = 1'b0;
    endtask

    task automatic get_resp(output resp_t r);
        r = '0;
        r.to = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                r = {1'b0, resp_op_id, resp_wr_rd, resp_data, resp_err};
                break;
            end
        end
        if (!r.to) begin
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        int pulses;
        pulses = 0;
        @(negedge clk);
        n_cmp++;
        if ({fifo_rd_en, resp_valid, resp_op_id, resp_wr_rd, resp_data, resp_err, busy, err_cnt} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", {fifo_rd_en, resp_valid, resp_op_id, resp_wr_rd, resp_data, resp_err, busy, err_cnt});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (fifo_rd_en || busy) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL idle_when_empty: got %0d active cycles expected 0", pulses);
        end
    endtask

    task automatic test_write_read();
        int    pulses;
        int    first_v;
        resp_t r;
        resp_t exp;
        pulses = 0;
        first_v = 0;
        r = '0;
        push(32'h000BA511);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (fifo_rd_en) pulses++;
            if (resp_valid && first_v == 0) begin
                first_v = k;
                r = {1'b0, resp_op_id, resp_wr_rd, resp_data, resp_err};
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL write_pop_pulses: got %0d expected 1", pulses);
        end
        n_cmp++;
        if (first_v !== 4) begin
            n_bad++;
            $display("FAIL write_latency: got cycle %0d expected 4", first_v);
        end
        exp = {1'b0, 8'h11, 1'b1, 8'hA5, 1'b0};
        n_cmp++;
        if (r !== exp) begin
            n_bad++;
            $display("FAIL write_resp: got %h expected %h", r, exp);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_cmp++;
        if ({resp_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL write_complete: got valid/busy %b expected 00", {resp_valid, busy});
        end
        push(32'h000A0012);
        get_resp(r);
        exp = {1'b0, 8'h12, 1'b0, 8'hA5, 1'b0};
        n_cmp++;
        if (r !== exp) begin
            n_bad++;
            $display("FAIL read_after_write: got %h expected %h", r, exp);
        end
    endtask

    task automatic test_backpressure();
        int    pops0;
        int    unstable;
        int    found;
        resp_t r;
        resp_t snap;
        resp_t exp;
        unstable = 0;
        found = 0;
        snap = '0;
        pops0 = pop_cnt;
        push(32'h00031121);
        push(32'h00020022);
        push(32'h00055A23);
        for (int n = 0; n < 20 && found == 0; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                found = 1;
                snap = {1'b0, resp_op_id, resp_wr_rd, resp_data, resp_err};
            end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!resp_valid || ({1'b0, resp_op_id, resp_wr_rd, resp_data, resp_err} !== snap)) unstable++;
        end
        n_cmp++;
        if (unstable !== 0 || found !== 1) begin
            n_bad++;
            $display("FAIL bp_hold_stable: got %0d unstable cycles (found=%0d) expected 0", unstable, found);
        end
        n_cmp++;
        if (pop_cnt - pops0 !== 1) begin
            n_bad++;
            $display("FAIL bp_pops_while_held: got %0d expected 1", pop_cnt - pops0);
        end
        exp = {1'b0, 8'h21, 1'b1, 8'h11, 1'b0};
        n_cmp++;
        if (snap !== exp) begin
            n_bad++;
            $display("FAIL bp_resp0: got %h expected %h", snap, exp);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        get_resp(r);
        exp = {1'b0, 8'h22, 1'b0, 8'h11, 1'b0};
        n_cmp++;
        if (r !== exp) begin
            n_bad++;
            $display("FAIL bp_resp1: got %h expected %h", r, exp);
        end
        get_resp(r);
        exp = {1'b0, 8'h23, 1'b1, 8'h5A, 1'b0};
        n_cmp++;
        if (r !== exp) begin
            n_bad++;
            $display("FAIL bp_resp2: got %h expected %h", r, exp);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pop_cnt - pops0 !== 3) begin
            n_bad++;
            $display("FAIL bp_total_pops: got %0d expected 3", pop_cnt - pops0);
        end
    endtask

    task automatic test_illegal();
        resp_t r;
        resp_t exp;
        push(32'h00293C07);
        get_resp(r);
        exp = {1'b0, 8'h07, 1'b1, 8'h00, 1'b1};
        n_cmp++;
        if (r !== exp || err_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL illegal_write: got %h cnt %h expected %h cnt 01", r, err_cnt, exp);
        end
        push(32'h00280008);
        get_resp(r);
        exp = {1'b0, 8'h08, 1'b0, 8'h00, 1'b1};
        n_cmp++;
        if (r !== exp || err_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL illegal_read: got %h cnt %h expected %h cnt 02", r, err_cnt, exp);
        end
        push(32'h00080030);
        get_resp(r);
        exp = {1'b0, 8'h30, 1'b0, 8'h00, 1'b0};
        n_cmp++;
        if (r !== exp) begin
            n_bad++;
            $display("FAIL alias_reg4_untouched: got %h expected %h", r, exp);
        end
        push(32'h000A0031);
        get_resp(r);
        exp = {1'b0, 8'h31, 1'b0, 8'hA5, 1'b0};
        n_cmp++;
        if (r !== exp) begin
            n_bad++;
            $display("FAIL reg5_kept: got %h expected %h", r, exp);
        end
        push(32'h80010000);
        get_resp(r);
        exp = {1'b0, 8'h00, 1'b1, 8'h00, 1'b1};
        n_cmp++;
        if (r !== exp || err_cnt !== 8'd3) begin
            n_bad++;
            $display("FAIL reserved_bit: got %h cnt %h expected %h cnt 03", r, err_cnt, exp);
        end
    endtask

    task automatic test_saturate();
        resp_t       r;
        int          lost;
        logic [31:0] f;
        lost = 0;
        for (int i = 0; i < 300; i++) begin
            f = 32'h80000000 | 32'(i & 255);
            push(f);
            get_resp(r);
            if (r.to || !r.err) lost++;
            if (i == 250) begin
                n_cmp++;
                if (err_cnt !== 8'hFE) begin
                    n_bad++;
                    $display("FAIL err_cnt_near_sat: got %h expected fe", err_cnt);
                end
            end
        end
        n_cmp++;
        if (err_cnt !== 8'hFF || lost !== 0) begin
            n_bad++;
            $display("FAIL err_cnt_saturate: got %h (bad responses %0d) expected ff (0)", err_cnt, lost);
        end
    endtask

    task automatic test_reset_mid();
        resp_t r;
        resp_t exp;
        int    seen;
        int    pops0;
        seen = 0;
        push(32'h00077741);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, resp_valid, fifo_rd_en, err_cnt} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_in_exec: got %h expected 0", {busy, resp_valid, fifo_rd_en, err_cnt});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pops0 = pop_cnt;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0 || pop_cnt !== pops0) begin
            n_bad++;
            $display("FAIL reset_no_resp: got %0d active cycles %0d pops expected 0 0", seen, pop_cnt - pops0);
        end
        push(32'h00060042);
        get_resp(r);
        exp = {1'b0, 8'h42, 1'b0, 8'h00, 1'b0};
        n_cmp++;
        if (r !== exp) begin
            n_bad++;
            $display("FAIL reg3_not_written: got %h expected %h", r, exp);
        end
        push(32'h00079943);
        get_resp(r);
        exp = {1'b0, 8'h43, 1'b1, 8'h99, 1'b0};
        n_cmp++;
        if (r !== exp) begin
            n_bad++;
            $display("FAIL post_reset_write: got %h expected %h", r, exp);
        end
        push(32'h00060044);
        get_resp(r);
        exp = {1'b0, 8'h44, 1'b0, 8'h99, 1'b0};
        n_cmp++;
        if (r !== exp) begin
            n_bad++;
            $display("FAIL post_reset_read: got %h expected %h", r, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fifo_empty = 1'b1;
        fifo_data = 32'd0;
        resp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_illegal();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
